// File: rtl/mor1kx_store_buffer_drain_if.sv
// Store-buffer drain interface: store buffer head, LSU control and data-bus
// write port, grouped so the drain sequencer connects through one port.
`timescale 1ns/1ps
interface mor1kx_store_buffer_drain_if #(
  parameter int OPTION_OPERAND_WIDTH = 32
);
  localparam int OW = OPTION_OPERAND_WIDTH;

  logic          sb_empty_i;
  logic          sb_read_o;
  logic [OW-1:0] sb_adr_i;
  logic [OW-1:0] sb_dat_i;
  logic [OW/8-1:0] sb_bsel_i;
  logic [OW-1:0] sb_pc_i;
  logic          sb_atomic_i;

  logic          pause_i;
  logic          atomic_flag_i;

  logic          dbus_req_o;
  logic          dbus_we_o;
  logic [OW-1:0] dbus_adr_o;
  logic [OW-1:0] dbus_dat_o;
  logic [OW/8-1:0] dbus_bsel_o;
  logic          dbus_ack_i;
  logic          dbus_err_i;

  logic          atomic_done_o;
  logic          atomic_success_o;
  logic          store_err_o;
  logic [OW-1:0] store_err_pc_o;
  logic          drained_o;

  modport master (
    input  sb_empty_i, sb_adr_i, sb_dat_i, sb_bsel_i, sb_pc_i, sb_atomic_i,
    output sb_read_o,
    input  pause_i, atomic_flag_i,
    output dbus_req_o, dbus_we_o, dbus_adr_o, dbus_dat_o, dbus_bsel_o,
    input  dbus_ack_i, dbus_err_i,
    output atomic_done_o, atomic_success_o, store_err_o, store_err_pc_o,
    output drained_o
  );

  modport slave (
    output sb_empty_i, sb_adr_i, sb_dat_i, sb_bsel_i, sb_pc_i, sb_atomic_i,
    input  sb_read_o,
    output pause_i, atomic_flag_i,
    input  dbus_req_o, dbus_we_o, dbus_adr_o, dbus_dat_o, dbus_bsel_o,
    output dbus_ack_i, dbus_err_i,
    input  atomic_done_o, atomic_success_o, store_err_o, store_err_pc_o,
    input  drained_o
  );
endinterface

// File: rtl/mor1kx_store_buffer_drain.sv
// Drains the store buffer FIFO onto the data bus one write per entry,
// resolving store-conditionals and flushing the queue after a bus fault.
`timescale 1ns/1ps
module mor1kx_store_buffer_drain #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_WIDTH        = 8
) (
  input logic clk,
  input logic rst,
  mor1kx_store_buffer_drain_if.master bus
);
  localparam int OW = OPTION_OPERAND_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DISCARD} state_t;

  state_t state, state_next;

  logic [OW-1:0]   adr_q, dat_q, pc_q, err_pc_q;
  logic [OW/8-1:0] bsel_q;
  logic            atomic_q;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;

  logic timeout, bus_fault;
  logic sb_read, atomic_done, atomic_success, store_err;

  assign timeout   = (wd_cnt == '1);
  assign bus_fault = bus.dbus_err_i || timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q    <= '0;
      dat_q    <= '0;
      bsel_q   <= '0;
      pc_q     <= '0;
      atomic_q <= 1'b0;
    end else if (state == FETCH) begin
      adr_q    <= bus.sb_adr_i;
      dat_q    <= bus.sb_dat_i;
      bsel_q   <= bus.sb_bsel_i;
      pc_q     <= bus.sb_pc_i;
      atomic_q <= bus.sb_atomic_i;
    end
  end

  // Watchdog is held at zero outside WRITE, so every write starts from 0
  // and saturates at all-ones, which is the timeout condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 wd_cnt <= '0;
    else if (state != WRITE)  wd_cnt <= '0;
    else if (!timeout)        wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            err_pc_q <= '0;
    else if (state == WRITE && bus_fault) err_pc_q <= pc_q;
  end

  always_comb begin
    state_next     = state;
    sb_read        = 1'b0;
    atomic_done    = 1'b0;
    atomic_success = 1'b0;
    store_err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.sb_empty_i && !bus.pause_i) begin
          sb_read    = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (bus.sb_atomic_i && !bus.atomic_flag_i) begin
          atomic_done = 1'b1;
          state_next  = IDLE;
        end else begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        // Error takes priority over a simultaneous ack.
        if (bus_fault) begin
          store_err  = 1'b1;
          state_next = DISCARD;
        end else if (bus.dbus_ack_i) begin
          atomic_done    = atomic_q;
          atomic_success = atomic_q;
          if (!bus.sb_empty_i && !bus.pause_i) begin
            sb_read    = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (bus.sb_empty_i) state_next = IDLE;
        else                sb_read    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sb_read_o        = sb_read;
  assign bus.dbus_req_o       = (state == WRITE);
  assign bus.dbus_we_o        = (state == WRITE);
  assign bus.dbus_adr_o       = adr_q;
  assign bus.dbus_dat_o       = dat_q;
  assign bus.dbus_bsel_o      = bsel_q;
  assign bus.atomic_done_o    = atomic_done;
  assign bus.atomic_success_o = atomic_success;
  assign bus.store_err_o      = store_err;
  assign bus.store_err_pc_o   = err_pc_q;
  assign bus.drained_o        = (state == IDLE) && bus.sb_empty_i;

endmodule

// File: tb/tb_mor1kx_store_buffer_drain.sv
// Bench for the store-buffer drain sequencer: FIFO and bus responder
// models driven once per cycle on the falling edge.
`timescale 1ns/1ps
module tb_mor1kx_store_buffer_drain;
  localparam int OW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mor1kx_store_buffer_drain_if #(.OPTION_OPERAND_WIDTH(OW)) bus ();

  mor1kx_store_buffer_drain #(
    .OPTION_OPERAND_WIDTH(OW),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] adr, dat, pc;
    logic [3:0]  bsel;
    logic        atomic;
  } entry_t;

  typedef struct {
    logic [31:0] adr, dat, pc;
    logic [3:0]  bsel;
    logic        atomic, flag;
    int          dly;
    logic        err, both;
    int          exp_wr, exp_adone;
    logic        exp_succ;
    int          exp_serr;
  } vec_t;

  entry_t fifo[$];
  int n_vec = 0, n_bad = 0;

  logic pause_cfg = 1'b0, flag_cfg = 1'b0, err_with_ack = 1'b0;
  int   ack_delay = 1, err_at = -1;

  int   cyc = 0, req_run = 0, wr_started = 0;
  logic pop_pending = 1'b0;
  int   n_reads, n_req, n_adone, n_serr;
  int   n_badpop = 0, n_badwe = 0;
  logic last_succ;
  int   first_read_cyc, first_req_cyc, last_ack_cyc, serr_cyc, adone_cyc;
  logic [31:0] wr_adr[$], wr_dat[$];
  logic [3:0]  wr_bsel[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] bsel, input logic [31:0] pc, input logic atomic);
    entry_t e;
    e.adr = adr; e.dat = dat; e.bsel = bsel; e.pc = pc; e.atomic = atomic;
    fifo.push_back(e);
  endtask

  task automatic clear_stats();
    n_reads = 0; n_req = 0; n_adone = 0; n_serr = 0; last_succ = 1'b0;
    first_read_cyc = -1; first_req_cyc = -1; last_ack_cyc = -1;
    serr_cyc = -1; adone_cyc = -1;
    wr_adr.delete(); wr_dat.delete(); wr_bsel.delete();
    wr_started = 0; req_run = 0;
    err_at = -1; err_with_ack = 1'b0;
  endtask

  // One clock cycle: apply inputs after the falling edge, sample 1 ns later.
  task automatic tick();
    entry_t e;
    logic req_now, fire, ack_now, err_now;
    @(negedge clk);
    cyc++;
    if (pop_pending && fifo.size() > 0) begin
      e = fifo.pop_front();
      bus.sb_adr_i = e.adr; bus.sb_dat_i = e.dat; bus.sb_bsel_i = e.bsel;
      bus.sb_pc_i = e.pc; bus.sb_atomic_i = e.atomic;
    end
    pop_pending = 1'b0;
    bus.sb_empty_i    = (fifo.size() == 0);
    bus.pause_i       = pause_cfg;
    bus.atomic_flag_i = flag_cfg;
    req_now = bus.dbus_req_o;
    fire    = req_now && (req_run == ack_delay);
    err_now = fire && (wr_started == err_at);
    ack_now = fire && (!err_now || err_with_ack);
    bus.dbus_ack_i = ack_now;
    bus.dbus_err_i = err_now;
    #1;
    if (bus.sb_read_o) begin
      if (bus.sb_empty_i) n_badpop++;
      pop_pending = 1'b1;
      n_reads++;
      if (first_read_cyc < 0) first_read_cyc = cyc;
    end
    if (bus.dbus_we_o !== bus.dbus_req_o) n_badwe++;
    if (bus.dbus_req_o) begin
      n_req++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (ack_now || err_now) begin
        wr_started++;
        req_run = 0;
        if (ack_now && !err_now) begin
          wr_adr.push_back(bus.dbus_adr_o);
          wr_dat.push_back(bus.dbus_dat_o);
          wr_bsel.push_back(bus.dbus_bsel_o);
          last_ack_cyc = cyc;
        end
      end else begin
        req_run++;
      end
    end else begin
      req_run = 0;
    end
    if (bus.atomic_done_o) begin
      n_adone++; last_succ = bus.atomic_success_o; adone_cyc = cyc;
    end
    if (bus.store_err_o) begin
      n_serr++; serr_cyc = cyc;
    end
  endtask

  task automatic run_until_drained(input string name, input int max);
    logic done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (bus.drained_o && fifo.size() == 0 && !pop_pending) done = 1'b1;
    end
    check({name, "_drained"}, 32'(done), 32'd1);
  endtask

  vec_t vt[8];

  initial begin
    //        adr       dat           pc        bsel  at    fl    dly err   both  wr adone succ  serr
    vt[0] = '{32'h100, 32'hA,        32'h1000, 4'hF, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1, 0,    1'b0, 0};
    vt[1] = '{32'h200, 32'h55,       32'h2000, 4'hF, 1'b1, 1'b0, 1,  1'b0, 1'b0, 0, 1,    1'b0, 0};
    vt[2] = '{32'h200, 32'h66,       32'h2000, 4'hF, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1, 1,    1'b1, 0};
    vt[3] = '{32'h10C, 32'hDEADBEEF, 32'h1010, 4'h3, 1'b0, 1'b1, 3,  1'b0, 1'b0, 1, 0,    1'b0, 0};
    vt[4] = '{32'h300, 32'h1,        32'h3004, 4'hF, 1'b0, 1'b0, 1,  1'b1, 1'b0, 0, 0,    1'b0, 1};
    vt[5] = '{32'h304, 32'h2,        32'h3008, 4'hF, 1'b1, 1'b1, 0,  1'b1, 1'b0, 0, 0,    1'b0, 1};
    vt[6] = '{32'h308, 32'h3,        32'h300C, 4'h1, 1'b0, 1'b0, 2,  1'b1, 1'b1, 0, 0,    1'b0, 1};
    vt[7] = '{32'h400, 32'h7,        32'h4000, 4'hC, 1'b0, 1'b0, 14, 1'b0, 1'b0, 1, 0,    1'b0, 0};

    bus.sb_empty_i = 1'b1; bus.sb_adr_i = '0; bus.sb_dat_i = '0; bus.sb_bsel_i = '0;
    bus.sb_pc_i = '0; bus.sb_atomic_i = 1'b0; bus.pause_i = 1'b0; bus.atomic_flag_i = 1'b0;
    bus.dbus_ack_i = 1'b0; bus.dbus_err_i = 1'b0;
    clear_stats();

    // Reset state, in reset and just after release
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(bus.dbus_req_o), 32'd0);
    check("rst_read", 32'(bus.sb_read_o), 32'd0);
    check("rst_drained", 32'(bus.drained_o), 32'd1);
    rst = 1'b1;
    tick();
    check("rel_req_we", {30'd0, bus.dbus_req_o, bus.dbus_we_o}, 32'd0);
    check("rel_adr", bus.dbus_adr_o, 32'd0);
    check("rel_dat", bus.dbus_dat_o, 32'd0);
    check("rel_bsel", 32'(bus.dbus_bsel_o), 32'd0);
    check("rel_flags", {28'd0, bus.sb_read_o, bus.atomic_done_o, bus.atomic_success_o,
                        bus.store_err_o}, 32'd0);
    check("rel_err_pc", bus.store_err_pc_o, 32'd0);
    check("rel_drained", 32'(bus.drained_o), 32'd1);

    // Single-entry vectors
    for (int i = 0; i < 8; i++) begin
      clear_stats();
      pause_cfg = 1'b0; flag_cfg = vt[i].flag; ack_delay = vt[i].dly;
      err_at = vt[i].err ? 0 : -1; err_with_ack = vt[i].both;
      push(vt[i].adr, vt[i].dat, vt[i].bsel, vt[i].pc, vt[i].atomic);
      run_until_drained($sformatf("v%0d", i), 40);
      check($sformatf("v%0d_reads", i), 32'(n_reads), 32'd1);
      check($sformatf("v%0d_writes", i), 32'(wr_adr.size()), 32'(vt[i].exp_wr));
      if (vt[i].exp_wr == 1 && wr_adr.size() == 1) begin
        check($sformatf("v%0d_adr", i), wr_adr[0], vt[i].adr);
        check($sformatf("v%0d_dat", i), wr_dat[0], vt[i].dat);
        check($sformatf("v%0d_bsel", i), 32'(wr_bsel[0]), 32'(vt[i].bsel));
      end
      if (vt[i].exp_serr == 0)
        check($sformatf("v%0d_req_cycles", i), 32'(n_req),
              32'(vt[i].exp_wr == 1 ? vt[i].dly + 1 : 0));
      check($sformatf("v%0d_adone", i), 32'(n_adone), 32'(vt[i].exp_adone));
      if (vt[i].exp_adone == 1) begin
        check($sformatf("v%0d_succ", i), 32'(last_succ), 32'(vt[i].exp_succ));
        check($sformatf("v%0d_adone_cyc", i), 32'(adone_cyc),
              32'(vt[i].exp_wr == 1 ? last_ack_cyc : first_read_cyc + 1));
      end
      check($sformatf("v%0d_serr", i), 32'(n_serr), 32'(vt[i].exp_serr));
      if (vt[i].exp_serr == 1)
        check($sformatf("v%0d_err_pc", i), bus.store_err_pc_o, vt[i].pc);
    end

    // Three entries back to back, ack one cycle after each request
    clear_stats();
    flag_cfg = 1'b0; ack_delay = 1;
    push(32'h100, 32'hA, 4'hF, 32'h1100, 1'b0);
    push(32'h104, 32'hB, 4'hF, 32'h1104, 1'b0);
    push(32'h108, 32'hC, 4'hF, 32'h1108, 1'b0);
    run_until_drained("b2b", 60);
    check("b2b_reads", 32'(n_reads), 32'd3);
    check("b2b_writes", 32'(wr_adr.size()), 32'd3);
    if (wr_adr.size() == 3)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("b2b_adr%0d", k), wr_adr[k], 32'h100 + 32'(4 * k));
        check($sformatf("b2b_dat%0d", k), wr_dat[k], 32'hA + 32'(k));
        check($sformatf("b2b_bsel%0d", k), 32'(wr_bsel[k]), 32'hF);
      end
    check("b2b_span", 32'(last_ack_cyc - first_read_cyc), 32'd9);

    // Error on the 2nd of four writes: remaining entries are discarded
    clear_stats();
    ack_delay = 1; err_at = 1;
    push(32'h500, 32'h10, 4'hF, 32'h3000, 1'b0);
    push(32'h504, 32'h11, 4'hF, 32'h3004, 1'b0);
    push(32'h508, 32'h12, 4'hF, 32'h3008, 1'b1);
    push(32'h50C, 32'h13, 4'hF, 32'h300C, 1'b0);
    run_until_drained("disc", 60);
    check("disc_writes", 32'(wr_adr.size()), 32'd1);
    check("disc_serr", 32'(n_serr), 32'd1);
    check("disc_err_pc", bus.store_err_pc_o, 32'h3004);
    check("disc_reads", 32'(n_reads), 32'd4);
    check("disc_req_cycles", 32'(n_req), 32'd4);
    check("disc_adone", 32'(n_adone), 32'd0);

    // Pause blocks pops; a write in flight still completes
    clear_stats();
    ack_delay = 2; pause_cfg = 1'b1;
    push(32'h600, 32'h20, 4'hF, 32'h6000, 1'b0);
    push(32'h604, 32'h21, 4'hF, 32'h6004, 1'b0);
    repeat (8) tick();
    check("pause_reads", 32'(n_reads), 32'd0);
    check("pause_req", 32'(n_req), 32'd0);
    pause_cfg = 1'b0;
    for (int i = 0; i < 20 && n_req == 0; i++) tick();
    check("pause_req_seen", 32'(n_req > 0), 32'd1);
    pause_cfg = 1'b1;
    repeat (10) tick();
    check("pause_mid_writes", 32'(wr_adr.size()), 32'd1);
    check("pause_mid_reads", 32'(n_reads), 32'd1);
    pause_cfg = 1'b0;
    run_until_drained("pause", 40);
    check("pause_writes", 32'(wr_adr.size()), 32'd2);
    check("pause_reads_end", 32'(n_reads), 32'd2);
    if (wr_adr.size() == 2) check("pause_adr1", wr_adr[1], 32'h604);

    // Ack withheld: watchdog fires 15 cycles after WRITE entry
    clear_stats();
    ack_delay = 1000;
    push(32'h700, 32'h30, 4'hF, 32'h5000, 1'b0);
    run_until_drained("tmo", 60);
    check("tmo_serr", 32'(n_serr), 32'd1);
    check("tmo_latency", 32'(serr_cyc - first_req_cyc), 32'd15);
    check("tmo_req_cycles", 32'(n_req), 32'd16);
    check("tmo_err_pc", bus.store_err_pc_o, 32'h5000);
    check("tmo_writes", 32'(wr_adr.size()), 32'd0);

    // Reset asserted in the middle of a write
    clear_stats();
    ack_delay = 1000;
    push(32'h800, 32'h40, 4'hF, 32'h8000, 1'b0);
    for (int i = 0; i < 20 && n_req == 0; i++) tick();
    check("mrst_req_seen", 32'(n_req > 0), 32'd1);
    rst = 1'b0;
    #1;
    check("mrst_req", 32'(bus.dbus_req_o), 32'd0);
    check("mrst_we", 32'(bus.dbus_we_o), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    clear_stats();
    run_until_drained("mrst", 10);
    check("mrst_idle_req", 32'(n_req), 32'd0);
    check("mrst_err_pc", bus.store_err_pc_o, 32'd0);

    check("pop_on_empty", 32'(n_badpop), 32'd0);
    check("we_follows_req", 32'(n_badwe), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, want finish before 1ms");
    $fatal(1);
  end

endmodule

// File: doc/mor1kx_store_buffer_drain.md
Name: mor1kx_store_buffer_drain

Overview:
- Sequencer that empties the store buffer FIFO onto the data bus.
- Pops the head entry and issues one bus write per entry; completes store-conditional (atomic) entries against the reservation flag.
- Detects bus error or timeout, discards the remaining queued stores and reports the faulting PC.
- Sits between the store buffer FIFO and the LSU's data-bus port; the LSU can pause draining to issue loads.

Parameters:
- OPTION_OPERAND_WIDTH, 32, address/data/pc width.
- TIMEOUT_WIDTH, 8, width of the ack watchdog counter. Timeout fires after 2^TIMEOUT_WIDTH-1 cycles without ack/err.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- sb_empty_i  in  1  store buffer empty.
- sb_read_o  out  1  pop strobe; the popped entry appears on sb_*_i the following cycle.
- sb_adr_i  in  OW  head entry address.
- sb_dat_i  in  OW  head entry data.
- sb_bsel_i  in  OW/8  head entry byte select.
- sb_pc_i  in  OW  head entry PC.
- sb_atomic_i  in  1  head entry is a store-conditional.
- pause_i  in  1  LSU requests bus; no new pop/issue starts while high.
- atomic_flag_i  in  1  reservation still valid.
- dbus_req_o  out  1  bus write request.
- dbus_we_o  out  1  write enable, equals dbus_req_o.
- dbus_adr_o  out  OW  bus address.
- dbus_dat_o  out  OW  bus data.
- dbus_bsel_o  out  OW/8  bus byte select.
- dbus_ack_i  in  1  bus acknowledge.
- dbus_err_i  in  1  bus error.
- atomic_done_o  out  1  one-cycle pulse: store-conditional resolved.
- atomic_success_o  out  1  valid with atomic_done_o; 1 = written.
- store_err_o  out  1  one-cycle pulse on bus error/timeout.
- store_err_pc_o  out  OW  PC of the faulting store; held until the next error.
- drained_o  out  1  state IDLE and sb_empty_i.

Behaviour:

States: IDLE, FETCH, WRITE, DISCARD. Reset value of the state register is IDLE.

Reset values: every output is 0; the registered bus fields and store_err_pc_o are 0.

- IDLE: if !sb_empty_i && !pause_i, assert sb_read_o (combinational) and go to FETCH.
- FETCH: capture sb_* into registers.
  - Non-atomic entry: go to WRITE.
  - Atomic entry with atomic_flag_i=1: go to WRITE.
  - Atomic entry with atomic_flag_i=0: pulse atomic_done_o=1 with atomic_success_o=0 in this cycle, issue no bus cycle, return to IDLE.
- WRITE: dbus_req_o/we_o=1 with the registered adr/dat/bsel, held stable until ack or err.
  - Watchdog counter clears on WRITE entry and increments each cycle.
  - ack (err=0):
    - Deassert req next cycle.
    - If the entry was atomic, pulse atomic_done_o=1 with atomic_success_o=1 in the ack cycle.
    - If !sb_empty_i && !pause_i in the ack cycle, assert sb_read_o and go to FETCH (back-to-back, no bubble); else go to IDLE.
  - err, or counter reaching all-ones:
    - Pulse store_err_o.
    - Load store_err_pc_o from the registered pc.
    - Go to DISCARD.
  - ack and err in the same cycle counts as error.
- DISCARD: assert sb_read_o every cycle while !sb_empty_i (ignores pause_i); no bus activity; return to IDLE when sb_empty_i. Discarded atomic entries produce no atomic_done_o.
- pause_i only blocks new pops. An issued write always completes.
- Pops are never issued while sb_empty_i=1. Exactly one pop per bus write in the non-error path.
- Reset mid-WRITE: req drops immediately (asynchronous), state returns to IDLE, the counter clears.
- Watchdog width: TIMEOUT_WIDTH; the counter saturates, no wrap.

Test Plan:
1. Reset low, then release with the FIFO empty. Required: all outputs 0, drained_o=1, no sb_read_o.
2. Push 3 entries (adr 0x100/0x104/0x108, dat 0xA/0xB/0xC, bsel 0xF); ack 1 cycle after each req. Required: three bus writes in order with matching fields, sb_read_o asserted 3 times, back-to-back with no idle cycle, drained_o=1 afterwards.
3. Atomic entry, pc=0x2000:
   - atomic_flag_i=0: no dbus_req_o; atomic_done_o=1, success=0 in FETCH.
   - Repeat with flag=1 and ack: one write, atomic_done_o=1, success=1 in the ack cycle.
4. 4 entries queued; err on the 2nd write (pc=0x3004). Required: store_err_o pulse, store_err_pc_o=0x3004, entries 3-4 popped without bus requests, then IDLE and drained_o=1.
5. pause_i=1 with 2 entries queued. Required: no pop. Raise pause_i during a WRITE: that write completes on ack, and the next pop waits until pause_i=0.
6. TIMEOUT_WIDTH=4 with ack withheld. Required: store_err_o fires 15 cycles after WRITE entry. Separately, assert reset mid-WRITE: dbus_req_o=0 immediately.
